// File: rtl/crc_lfsr_stream_if.sv
// Message-word and CRC-result handshake bundle for crc_lfsr_stream.
// master drives words in and accepts results; slave is the CRC engine.
interface crc_lfsr_stream_if #(
  parameter int DATA_W = 10,
  parameter int CRC_W  = 9
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [CRC_W-1:0]  out_crc;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_crc
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_crc
  );
endinterface

// File: rtl/crc_lfsr_stream.sv
// Serial LFSR CRC over a word stream, BPC bits per clock, MSB first; result DATA_W/BPC cycles after last word.
// One word in flight: in_ready only in IDLE; result held in DONE until out_ready.
module crc_lfsr_stream #(
  parameter int               CRC_W   = 9,
  parameter logic [CRC_W-1:0] POLY    = 9'h103,
  parameter int               DATA_W  = 10,
  parameter int               BPC     = 1,
  parameter logic [CRC_W-1:0] INIT    = '0,
  parameter logic [CRC_W-1:0] XOR_OUT = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 abort,
  crc_lfsr_stream_if.slave     bus,
  output logic                 busy
);

  localparam int NCHUNK = DATA_W / BPC;
  localparam int CNT_W  = $clog2(NCHUNK + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state;
  logic [CRC_W-1:0]  crc;
  logic [CRC_W-1:0]  crc_next;
  logic [DATA_W-1:0] data_q;
  logic              last_q;
  logic [CNT_W-1:0]  cnt;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              fb_bit;

  // Fold the top BPC bits of the captured word into the register in one cycle.
  always_comb begin
    crc_next = crc;
    fb_bit   = 1'b0;
    for (int i = 0; i < BPC; i++) begin
      fb_bit   = crc_next[CRC_W-1] ^ data_q[DATA_W-1-i];
      crc_next = {crc_next[CRC_W-2:0], 1'b0} ^ (fb_bit ? POLY : '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      crc         <= INIT;
      cnt         <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
    end else if (abort) begin
      state       <= IDLE;
      crc         <= INIT;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data_q     <= bus.in_data;
            last_q     <= bus.in_last;
            cnt        <= CNT_W'(NCHUNK);
            state      <= SHIFT;
            in_ready_q <= 1'b0;
            busy       <= 1'b1;
          end
        end
        SHIFT: begin
          crc    <= crc_next;
          data_q <= data_q << BPC;
          cnt    <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            // A non-final word keeps crc so the next word continues the message.
            if (last_q) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state      <= IDLE;
              in_ready_q <= 1'b1;
              busy       <= 1'b0;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            crc         <= INIT;
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy        <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_crc   = crc ^ XOR_OUT;

endmodule

// File: tb/tb_crc_lfsr_stream.sv
// Directed bench for crc_lfsr_stream: default-parameter instance plus a BPC=2 instance.
module tb_crc_lfsr_stream;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic abort = 1'b0;
  logic abort2 = 1'b0;
  logic busy, busy2;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  crc_lfsr_stream_if #(.DATA_W(10), .CRC_W(9)) if0 ();
  crc_lfsr_stream_if #(.DATA_W(10), .CRC_W(9)) if1 ();

  crc_lfsr_stream dut (
    .clk   (clk),
    .reset (reset),
    .abort (abort),
    .bus   (if0),
    .busy  (busy)
  );

  crc_lfsr_stream #(.BPC(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .abort (abort2),
    .bus   (if1),
    .busy  (busy2)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Ticks until if0.out_valid, bounded; returns number of edges waited.
  task automatic wait_out0(output int n);
    n = 0;
    while (!if0.out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rc;
    int seen;
    bit armed;

    if0.in_valid = 1'b0; if0.in_data = '0; if0.in_last = 1'b0; if0.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.in_data = '0; if1.in_last = 1'b0; if1.out_ready = 1'b0;
    tick();
    tick();

    // Reset values
    chk("rst_in_ready", 32'(if0.in_ready), 32'd1);
    chk("rst_out_valid", 32'(if0.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_crc", 32'(if0.out_crc), 32'h000);
    reset = 1'b0;
    tick();

    // Single word 0x200, with ignored in_valid/in_data traffic during SHIFT
    if0.in_valid = 1'b1; if0.in_data = 10'h200; if0.in_last = 1'b1;
    tick();
    if0.in_data = 10'h3FF; if0.in_last = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_in_ready", 32'(if0.in_ready), 32'd0);
    tick(); tick(); tick();
    if0.in_valid = 1'b0;
    wait_out0(n);
    chk("t1_latency", 32'(n + 3), 32'd10);
    chk("t1_crc", 32'(if0.out_crc), 32'h004);
    if0.out_ready = 1'b1;
    tick();
    if0.out_ready = 1'b0;
    chk("t1_out_valid_drop", 32'(if0.out_valid), 32'd0);
    chk("t1_idle_ready", 32'(if0.in_ready), 32'd1);
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // Two-word message 0x200 then 0x000
    if0.in_valid = 1'b1; if0.in_data = 10'h200; if0.in_last = 1'b0;
    tick();
    if0.in_data = 10'h000; if0.in_last = 1'b1;
    n = 0; rc = 0; armed = 1'b0;
    while (!if0.out_valid && n < 40) begin
      tick();
      n++;
      if (if0.in_ready) begin
        rc++;
        armed = 1'b1;
      end else if (armed) begin
        if0.in_valid = 1'b0;
        armed = 1'b0;
      end
    end
    if0.in_valid = 1'b0;
    chk("t2_latency", 32'(n), 32'd21);
    chk("t2_gap", 32'(rc), 32'd1);
    chk("t2_crc", 32'(if0.out_crc), 32'h111);
    if0.out_ready = 1'b1;
    tick();
    if0.out_ready = 1'b0;

    // BPC=2 instance, single word 0x200
    if1.in_valid = 1'b1; if1.in_data = 10'h200; if1.in_last = 1'b1;
    tick();
    if1.in_valid = 1'b0;
    n = 0;
    while (!if1.out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("t3_latency", 32'(n), 32'd5);
    chk("t3_crc", 32'(if1.out_crc), 32'h004);
    if1.out_ready = 1'b1;
    tick();
    if1.out_ready = 1'b0;
    chk("t3_idle_ready", 32'(if1.in_ready), 32'd1);

    // Result held while out_ready is low
    if0.in_valid = 1'b1; if0.in_data = 10'h000; if0.in_last = 1'b1;
    tick();
    if0.in_valid = 1'b0;
    wait_out0(n);
    chk("t4_latency", 32'(n), 32'd10);
    seen = 0;
    for (int k = 0; k < 7; k++) begin
      if (if0.out_valid && if0.out_crc == 9'h000) seen++;
      tick();
    end
    chk("t4_hold", 32'(seen), 32'd7);
    chk("t4_still_valid", 32'(if0.out_valid), 32'd1);
    if0.out_ready = 1'b1;
    tick();
    if0.out_ready = 1'b0;
    chk("t4_idle_ready", 32'(if0.in_ready), 32'd1);
    chk("t4_valid_low", 32'(if0.out_valid), 32'd0);

    // Abort in the 4th SHIFT cycle
    if0.in_valid = 1'b1; if0.in_data = 10'h200; if0.in_last = 1'b1;
    tick();
    if0.in_valid = 1'b0;
    tick(); tick(); tick();
    chk("t5_mid_crc", 32'(if0.out_crc), 32'h109);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_ready", 32'(if0.in_ready), 32'd1);
    chk("t5_abort_busy", 32'(busy), 32'd0);
    chk("t5_abort_crc", 32'(if0.out_crc), 32'h000);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (if0.out_valid) seen++;
      tick();
    end
    chk("t5_no_valid", 32'(seen), 32'd0);
    // Abort outranks acceptance
    if0.in_valid = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0; if0.in_valid = 1'b0;
    chk("t5_prio_ready", 32'(if0.in_ready), 32'd1);
    chk("t5_prio_busy", 32'(busy), 32'd0);
    if0.in_valid = 1'b1;
    tick();
    if0.in_valid = 1'b0;
    wait_out0(n);
    chk("t5_latency", 32'(n), 32'd10);
    chk("t5_crc", 32'(if0.out_crc), 32'h004);
    if0.out_ready = 1'b1;
    tick();
    if0.out_ready = 1'b0;

    // Reset pulse mid-SHIFT
    if0.in_valid = 1'b1; if0.in_data = 10'h200; if0.in_last = 1'b1;
    tick();
    if0.in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk("t6_rst_ready", 32'(if0.in_ready), 32'd1);
    chk("t6_rst_valid", 32'(if0.out_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_crc", 32'(if0.out_crc), 32'h000);
    tick();
    reset = 1'b0;
    if0.in_valid = 1'b1;
    tick();
    if0.in_valid = 1'b0;
    chk("t6_accept", 32'(busy), 32'd1);
    wait_out0(n);
    chk("t6_latency", 32'(n), 32'd10);
    chk("t6_crc", 32'(if0.out_crc), 32'h004);
    if0.out_ready = 1'b1;
    tick();
    if0.out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
